// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width, integration defaults and read-engine state type.
package fifo_pkg;
    localparam int DATA_WIDTH  = 8;
    localparam int TX_COUNT_RD = 120;
    localparam int READ_DELAY  = 0;
    typedef enum logic [2:0] {ST_IDLE, ST_DELAY, ST_READ, ST_DRAIN, ST_DONE} rd_state_e;
endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: two-entry skid buffer, valid/ready on both sides, oldest entry at the head.
module fifo_rd_skid #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [1:0]            occ_o
);
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic                  push, pop;
    assign in_ready_o  = occ_q != 2'd2;
    assign out_valid_o = occ_q != 2'd0;
    assign out_data_o  = ent0_q;
    assign occ_o       = occ_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    always_comb begin
        occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
        ent0_d = pop ? ((push && occ_q == 2'd1) ? in_data_i : ent1_q)
                     : ((push && occ_q == 2'd0) ? in_data_i : ent0_q);
        ent1_d = (push && occ_q == 2'd1 && !pop) ? in_data_i : ent1_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q  <= '0;
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            occ_q  <= occ_d;
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
        end
    end
endmodule

// File: rtl/fifo_rd_engine.sv
// fifo_rd_engine: reads TX_COUNT words from a FIFO into a skid buffer and streams them out.
// Optional in-order data checker enabled by defining FIFO_RD_CHECK_EN.
module fifo_rd_engine #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int TX_COUNT   = fifo_pkg::TX_COUNT_RD,
    parameter int READ_DELAY = fifo_pkg::READ_DELAY
) (
    input  logic                  clk_rd,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           rd_count,
    output logic [15:0]           err_count
);
    import fifo_pkg::*;
    localparam logic [15:0] TXC      = 16'(TX_COUNT);
    localparam logic [15:0] DLY_LAST = 16'(READ_DELAY - 1);
    rd_state_e   state_q, state_d;
    logic [15:0] dly_q, dly_d, issued_q, issued_d, rd_count_q, rd_count_d;
    logic [1:0]  occ;
    logic        inflight_q, pop, go, skid_rdy;
    assign go        = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign pop       = out_valid && out_ready;
    // Credit check: skid occupancy plus the word in flight must leave room after this cycle's pop.
    assign rd_en     = state_q == ST_READ && !empty && issued_q < TXC
                       && (3'(occ) + 3'(inflight_q)) < (3'd2 + 3'(pop));
    assign busy      = state_q == ST_DELAY || state_q == ST_READ || state_q == ST_DRAIN;
    assign done      = state_q == ST_DONE;
    assign rd_count  = rd_count_q;
    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        issued_d   = issued_q + 16'(rd_en);
        rd_count_d = rd_count_q + 16'(pop);
        case (state_q)
            ST_IDLE, ST_DONE: if (go) begin
                issued_d   = '0;
                rd_count_d = '0;
                dly_d      = '0;
                state_d    = (READ_DELAY > 0) ? ST_DELAY : ST_READ;
            end
            ST_DELAY: begin
                dly_d   = dly_q + 16'd1;
                state_d = (dly_q == DLY_LAST) ? ST_READ : ST_DELAY;
            end
            ST_READ:  state_d = (issued_d == TXC) ? ST_DRAIN : ST_READ;
            ST_DRAIN: state_d = (occ == 2'd0 && !inflight_q) ? ST_DONE : ST_DRAIN;
            default:  state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dly_q      <= '0;
            issued_q   <= '0;
            rd_count_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            issued_q   <= issued_d;
            rd_count_q <= rd_count_d;
            inflight_q <= rd_en;
        end
    end
    fifo_rd_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk_i      (clk_rd),
        .rst_ni     (rst_n),
        .in_valid_i (inflight_q && skid_rdy),
        .in_ready_o (skid_rdy),
        .in_data_i  (rd_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .occ_o      (occ)
    );
`ifdef FIFO_RD_CHECK_EN
    logic [DATA_WIDTH-1:0] exp_q;
    logic [15:0]           err_q;
    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= '0;
            err_q <= '0;
        end else if (go) begin
            exp_q <= '0;
            err_q <= '0;
        end else if (pop) begin
            exp_q <= exp_q + DATA_WIDTH'(1);
            if (out_data != exp_q && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
        end
    end
    assign err_count = err_q;
`else
    assign err_count = 16'd0;
`endif
endmodule
